decode_stage: RTL and testbench
===============================

# decode_stage

Second pipeline stage. Consumes the 64-bit fetch/decode buffer, which holds the input-port value, PC+1 and the 16-bit instruction word. It merges two-word (immediate) instructions, reads the 8×16-bit register file, and registers a 108-bit decode/execute buffer. Writeback returns through the register-file write port.

## Interface
Parameters:
- none; widths are fixed by the instruction set.

Ports:
- Clk  in  1  rising-edge clock; the only clock.
- Rst  in  1  synchronous, active-high reset.
- In  in  64  fetch buffer: [15:0] instruction word, [47:16] PC+1, [63:48] input-port value.
- Stall  in  1  hazard hold: freeze state, buffer and capture registers.
- Flush  in  1  taken jump/RET/RTI/interrupt: discard the current word and any pending first word.
- WbEn  in  1  register-file write enable.
- WbAddr  in  3  write register index.
- WbData  in  16  write data.
- Out  out  108  decode buffer: [0] valid, [5:1] opcode, [8:6] Rdst, [11:9] Rsrc, [27:12] R[Rsrc], [43:28] R[Rdst], [59:44] immediate, [91:60] PC+1, [107:92] input-port value.

## Operation
- Instruction word format: [15:11] opcode, [10:8] Rdst, [7:5] Rsrc, [4:1] unused, [0] IMM. When IMM=1 the next fetched word is the 16-bit immediate.
- Opcode 5'b00000 is NOP. Its IMM bit is ignored, so a NOP never starts a two-word sequence.
- FSM states:
  - FIRST (reset state). The word is an opcode word.
    - IMM=0: emit the decoded instruction with valid=1 and immediate=0. Stay in FIRST.
    - IMM=1: latch opcode, Rdst and Rsrc into capture registers. Emit a bubble (Out all zero). Go to WAIT_IMM.
  - WAIT_IMM. The word is the immediate. Emit the captured opcode, Rdst and Rsrc with immediate = In[15:0], valid=1. Return to FIRST.
    - PC+1 and input-port fields come from the immediate word's buffer, so CALL pushes the address after the immediate.
- Register file: 8×16 bits, two asynchronous read ports addressed by the emitted Rsrc and Rdst, one synchronous write port.
  - Write-first: when WbEn=1 and WbAddr matches a read address in the same cycle, the read returns WbData.
  - R0 is an ordinary register.
- Bubble: Out = 108'b0, including valid=0.
- Priority per cycle: Rst > Flush > Stall > normal.
  - Flush: Out ← bubble, FSM ← FIRST, capture registers cleared.
  - Stall: Out, FSM and capture registers hold. Register-file writes still occur.

## Timing
- All outputs registered. One-word instruction: Out valid on the edge after it is present on In.
- Two-word instruction: a bubble on the edge after the opcode word, the full instruction on the edge after the immediate word. Net latency is 2 cycles from the opcode word, with one bubble.
- Reset: Out = 0, FSM = FIRST, capture registers = 0, all registers R0–R7 = 0. These hold on the first edge with Rst=1.
- Stall held for N cycles in WAIT_IMM: the immediate is taken from In on the first non-stalled edge. Fetch holds In stable while stalled.
- Flush and Stall together: Flush wins.
- Flush in WAIT_IMM: the pending instruction is dropped, and the next word is decoded as an opcode word.
- Rst mid two-word sequence: the sequence is dropped, and the next word is decoded as an opcode word.
- A writeback to the same register in the cycle the instruction is emitted is visible in the emitted data (write-first).

## Structure
- Shared package/header holds:
  - opcode constants (NOP = 5'b00000);
  - FSM state encodings (FIRST, WAIT_IMM);
  - Out field-position constants;
  - In field-position constants, shared with fetch.
- One sub-module: register_file_8x16 (two asynchronous read ports, one synchronous write port, synchronous reset, write-first bypass).
- The FSM, capture registers and output register live in decode_stage.

## Test plan
- Reset, then In = {16'h00AA, 32'h00000001, 16'h0000} -> Out = {16'h00AA, 32'h1, 16'h0, 0,0,0, 5'b0, valid=1}, with register data 0.
- WbEn=1, WbAddr=3, WbData=16'h1234 in the same cycle as In[15:0] = {5'b01001, 3'd3, 3'd3, 4'b0, 1'b0} -> Out[43:28] = Out[27:12] = 16'h1234 on the next edge (write-first).
- Opcode word with IMM=1, opcode 5'b10010, Rdst=5, then word 16'hBEEF with PC+1 = 32'h12:
  - next edge: Out = 0;
  - following edge: valid=1, opcode 5'b10010, Rdst=5, immediate 16'hBEEF, PC+1 32'h12.
- Same two-word sequence with Stall=1 for 3 cycles while in WAIT_IMM -> Out holds the bubble; the full instruction appears one edge after Stall drops.
- Flush=1 on the immediate cycle -> Out = 0. The next word 16'hBEEF (opcode 5'b10111, Rdst 6, Rsrc 7, IMM 1) is treated as an opcode word, so Out = 0 and the FSM enters WAIT_IMM.
- Stall=1 and Flush=1 together while a valid instruction sits in Out -> Out becomes 0 and FSM = FIRST. A NOP word with IMM=1 -> valid NOP emitted, FSM stays FIRST.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared decode-stage definitions: opcodes, FSM states and buffer field positions.
package decode_stage_pkg;

  localparam logic [4:0] OpNop = 5'b00000;

  typedef enum logic [0:0] {
    StFirst   = 1'b0,
    StWaitImm = 1'b1
  } dec_state_e;

  // Fetch/decode buffer layout, shared with fetch.
  localparam int unsigned InWidth    = 64;
  localparam int unsigned InImmBit   = 0;
  localparam int unsigned InRsrcLsb  = 5;
  localparam int unsigned InRsrcMsb  = 7;
  localparam int unsigned InRdstLsb  = 8;
  localparam int unsigned InRdstMsb  = 10;
  localparam int unsigned InOpLsb    = 11;
  localparam int unsigned InOpMsb    = 15;
  localparam int unsigned InWordLsb  = 0;
  localparam int unsigned InWordMsb  = 15;
  localparam int unsigned InPcLsb    = 16;
  localparam int unsigned InPcMsb    = 47;
  localparam int unsigned InPortLsb  = 48;
  localparam int unsigned InPortMsb  = 63;

  // Decode/execute buffer layout.
  localparam int unsigned OutWidth     = 108;
  localparam int unsigned OutValidBit  = 0;
  localparam int unsigned OutOpLsb     = 1;
  localparam int unsigned OutOpMsb     = 5;
  localparam int unsigned OutRdstLsb   = 6;
  localparam int unsigned OutRdstMsb   = 8;
  localparam int unsigned OutRsrcLsb   = 9;
  localparam int unsigned OutRsrcMsb   = 11;
  localparam int unsigned OutRsDataLsb = 12;
  localparam int unsigned OutRsDataMsb = 27;
  localparam int unsigned OutRdDataLsb = 28;
  localparam int unsigned OutRdDataMsb = 43;
  localparam int unsigned OutImmLsb    = 44;
  localparam int unsigned OutImmMsb    = 59;
  localparam int unsigned OutPcLsb     = 60;
  localparam int unsigned OutPcMsb     = 91;
  localparam int unsigned OutPortLsb   = 92;
  localparam int unsigned OutPortMsb   = 107;

endpackage

// File: rtl/decode_stage_regfile.sv
// 8x16 register file: two asynchronous write-first read ports, one synchronous write port.
module register_file_8x16 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic [2:0]  waddr_i,
  input  logic [15:0] wdata_i,
  input  logic [2:0]  raddr_a_i,
  output logic [15:0] rdata_a_o,
  input  logic [2:0]  raddr_b_i,
  output logic [15:0] rdata_b_o
);

  logic [15:0] regs_q [8];
  logic [15:0] regs_d [8];

  // Next-state: single write per cycle.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (we_i) begin
      regs_d[waddr_i] = wdata_i;
    end
  end

  // Register storage with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= 16'h0000;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Read ports bypass a same-cycle write so the consumer sees the new value.
  always_comb begin
    rdata_a_o = (we_i && (waddr_i == raddr_a_i)) ? wdata_i : regs_q[raddr_a_i];
    rdata_b_o = (we_i && (waddr_i == raddr_b_i)) ? wdata_i : regs_q[raddr_b_i];
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: merges two-word instructions, reads the register file, registers the
// decode/execute buffer.
module decode_stage
  import decode_stage_pkg::*;
(
  input  logic         Clk,
  input  logic         Rst,
  input  logic [63:0]  In,
  input  logic         Stall,
  input  logic         Flush,
  input  logic         WbEn,
  input  logic [2:0]   WbAddr,
  input  logic [15:0]  WbData,
  output logic [107:0] Out
);

  dec_state_e           state_q, state_d;
  logic [4:0]           cap_op_q, cap_op_d;
  logic [2:0]           cap_rdst_q, cap_rdst_d;
  logic [2:0]           cap_rsrc_q, cap_rsrc_d;
  logic [OutWidth-1:0]  out_q, out_d;

  logic [4:0]  in_op;
  logic [2:0]  in_rdst, in_rsrc;
  logic        in_imm;
  logic [4:0]  sel_op;
  logic [2:0]  sel_rdst, sel_rsrc;
  logic [15:0] rs_data, rd_data;
  logic        unused_in;

  assign in_op     = In[InOpMsb:InOpLsb];
  assign in_rdst   = In[InRdstMsb:InRdstLsb];
  assign in_rsrc   = In[InRsrcMsb:InRsrcLsb];
  assign in_imm    = In[InImmBit];
  assign unused_in = ^In[4:1];

  // Fields that would be emitted this cycle: fresh from In, or captured for an immediate.
  always_comb begin
    if (state_q == StWaitImm) begin
      sel_op   = cap_op_q;
      sel_rdst = cap_rdst_q;
      sel_rsrc = cap_rsrc_q;
    end else begin
      sel_op   = in_op;
      sel_rdst = in_rdst;
      sel_rsrc = in_rsrc;
    end
  end

  register_file_8x16 u_regfile (
    .clk_i     (Clk),
    .rst_i     (Rst),
    .we_i      (WbEn),
    .waddr_i   (WbAddr),
    .wdata_i   (WbData),
    .raddr_a_i (sel_rsrc),
    .rdata_a_o (rs_data),
    .raddr_b_i (sel_rdst),
    .rdata_b_o (rd_data)
  );

  // Next-state: Flush > Stall > normal decode.
  always_comb begin
    state_d    = state_q;
    cap_op_d   = cap_op_q;
    cap_rdst_d = cap_rdst_q;
    cap_rsrc_d = cap_rsrc_q;
    out_d      = out_q;

    if (Flush) begin
      state_d    = StFirst;
      cap_op_d   = 5'b0;
      cap_rdst_d = 3'b0;
      cap_rsrc_d = 3'b0;
      out_d      = '0;
    end else if (!Stall) begin
      // NOP never starts a two-word sequence, whatever its IMM bit says.
      if ((state_q == StFirst) && in_imm && (in_op != OpNop)) begin
        state_d    = StWaitImm;
        cap_op_d   = in_op;
        cap_rdst_d = in_rdst;
        cap_rsrc_d = in_rsrc;
        out_d      = '0;
      end else begin
        state_d                           = StFirst;
        out_d                             = '0;
        out_d[OutValidBit]                = 1'b1;
        out_d[OutOpMsb:OutOpLsb]          = sel_op;
        out_d[OutRdstMsb:OutRdstLsb]      = sel_rdst;
        out_d[OutRsrcMsb:OutRsrcLsb]      = sel_rsrc;
        out_d[OutRsDataMsb:OutRsDataLsb]  = rs_data;
        out_d[OutRdDataMsb:OutRdDataLsb]  = rd_data;
        out_d[OutPcMsb:OutPcLsb]          = In[InPcMsb:InPcLsb];
        out_d[OutPortMsb:OutPortLsb]      = In[InPortMsb:InPortLsb];
        if (state_q == StWaitImm) begin
          out_d[OutImmMsb:OutImmLsb] = In[InWordMsb:InWordLsb];
        end
      end
    end
  end

  // State, capture and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= StFirst;
      cap_op_q   <= 5'b0;
      cap_rdst_q <= 3'b0;
      cap_rsrc_q <= 3'b0;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      cap_op_q   <= cap_op_d;
      cap_rdst_q <= cap_rdst_d;
      cap_rsrc_q <= cap_rsrc_d;
      out_q      <= out_d;
    end
  end

  assign Out = out_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with an expected-output scoreboard queue.
module tb_decode_stage;

  logic         Clk = 1'b0;
  logic         Rst = 1'b1;
  logic [63:0]  In = '0;
  logic         Stall = 1'b0;
  logic         Flush = 1'b0;
  logic         WbEn = 1'b0;
  logic [2:0]   WbAddr = '0;
  logic [15:0]  WbData = '0;
  logic [107:0] Out;

  int total = 0;
  int bad = 0;
  logic [107:0] exp_q[$];

  decode_stage dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .In     (In),
    .Stall  (Stall),
    .Flush  (Flush),
    .WbEn   (WbEn),
    .WbAddr (WbAddr),
    .WbData (WbData),
    .Out    (Out)
  );

  always #5 Clk = ~Clk;

  function automatic logic [107:0] mk(input logic [4:0] op, input logic [2:0] rdst,
                                      input logic [2:0] rsrc, input logic [15:0] rsv,
                                      input logic [15:0] rdv, input logic [15:0] imm,
                                      input logic [31:0] pc, input logic [15:0] port);
    return {port, pc, imm, rdv, rsv, rsrc, rdst, op, 1'b1};
  endfunction

  function automatic logic [63:0] fb(input logic [15:0] port, input logic [31:0] pc,
                                     input logic [15:0] word);
    return {port, pc, word};
  endfunction

  // Drive one cycle, queue the expectation, compare after the edge.
  task automatic step(input logic rst, input logic stall, input logic flush,
                      input logic [63:0] in, input logic wben, input logic [2:0] wa,
                      input logic [15:0] wd, input logic [107:0] exp, input string tag);
    logic [107:0] e;
    logic [107:0] got;
    Rst = rst; Stall = stall; Flush = flush; In = in;
    WbEn = wben; WbAddr = wa; WbData = wd;
    exp_q.push_back(exp);
    @(posedge Clk);
    #1;
    got = Out;
    e = exp_q.pop_front();
    total++;
    assert (got === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, e);
    end
  endtask

  localparam logic [107:0] Z = '0;

  initial begin
    #1;
    // Reset
    step(1, 0, 0, fb(16'h00AA, 32'h1, 16'h0000), 0, 0, 0, Z, "reset0");
    step(1, 0, 0, fb(16'h00AA, 32'h1, 16'h0000), 1, 3'd4, 16'h9999, Z, "reset1");
    // One-word NOP
    step(0, 0, 0, fb(16'h00AA, 32'h1, 16'h0000), 0, 0, 0,
         mk(5'd0, 0, 0, 0, 0, 0, 32'h1, 16'h00AA), "nop_word");
    // Write-first bypass on both ports
    step(0, 0, 0, fb(16'h0, 32'h2, 16'h4B60), 1, 3'd3, 16'h1234,
         mk(5'b01001, 3, 3, 16'h1234, 16'h1234, 0, 32'h2, 0), "write_first");
    // Two-word instruction
    step(0, 0, 0, fb(16'h0, 32'h11, 16'h9561), 0, 0, 0, Z, "imm_bubble");
    step(0, 0, 0, fb(16'h0, 32'h12, 16'hBEEF), 0, 0, 0,
         mk(5'b10010, 5, 3, 16'h1234, 16'h0, 16'hBEEF, 32'h12, 0), "imm_full");
    // Two-word with 3-cycle stall in WAIT_IMM; writeback during stall still lands
    step(0, 0, 0, fb(16'h0, 32'h20, 16'h9561), 0, 0, 0, Z, "stall_bubble");
    step(0, 1, 0, fb(16'h7, 32'h21, 16'hBEEF), 1, 3'd5, 16'h5555, Z, "stall_hold0");
    step(0, 1, 0, fb(16'h7, 32'h21, 16'hBEEF), 0, 0, 0, Z, "stall_hold1");
    step(0, 1, 0, fb(16'h7, 32'h21, 16'hBEEF), 0, 0, 0, Z, "stall_hold2");
    step(0, 0, 0, fb(16'h7, 32'h21, 16'hBEEF), 0, 0, 0,
         mk(5'b10010, 5, 3, 16'h1234, 16'h5555, 16'hBEEF, 32'h21, 16'h7), "stall_release");
    // Flush in WAIT_IMM: next word is an opcode word
    step(0, 0, 0, fb(16'h0, 32'h30, 16'h9561), 0, 0, 0, Z, "flush_pre");
    step(0, 0, 1, fb(16'h0, 32'h31, 16'hBEEF), 0, 0, 0, Z, "flush_imm");
    step(0, 0, 0, fb(16'h0, 32'h32, 16'hBEEF), 0, 0, 0, Z, "after_flush_opword");
    step(0, 0, 0, fb(16'h0, 32'h40, 16'h0042), 0, 0, 0,
         mk(5'b10111, 6, 7, 0, 0, 16'h0042, 32'h40, 0), "after_flush_imm");
    // Stall+Flush together with valid Out
    step(0, 0, 0, fb(16'h0, 32'h50, 16'h1940), 0, 0, 0,
         mk(5'b00011, 1, 2, 0, 0, 0, 32'h50, 0), "one_word");
    step(0, 1, 1, fb(16'h0, 32'h51, 16'h9561), 0, 0, 0, Z, "stall_flush");
    // NOP with IMM=1 stays one word
    step(0, 0, 0, fb(16'h0, 32'h60, 16'h03A1), 0, 0, 0,
         mk(5'd0, 3, 5, 16'h5555, 16'h1234, 0, 32'h60, 0), "nop_imm");
    step(0, 0, 0, fb(16'h0, 32'h61, 16'h1940), 0, 0, 0,
         mk(5'b00011, 1, 2, 0, 0, 0, 32'h61, 0), "after_nop_imm");
    // Stall holds a valid output
    step(0, 1, 0, fb(16'hFFFF, 32'h62, 16'h4B60), 0, 0, 0,
         mk(5'b00011, 1, 2, 0, 0, 0, 32'h61, 0), "stall_valid_hold");
    // Write to R0 bypass
    step(0, 0, 0, fb(16'h0, 32'h63, 16'h0800), 1, 3'd0, 16'hA5A5,
         mk(5'b00001, 0, 0, 16'hA5A5, 16'hA5A5, 0, 32'h63, 0), "r0_write_first");
    // Reset mid two-word sequence drops it and clears registers
    step(0, 0, 0, fb(16'h0, 32'h70, 16'h9561), 0, 0, 0, Z, "rst_mid_pre");
    step(1, 0, 0, fb(16'h0, 32'h71, 16'hBEEF), 0, 0, 0, Z, "rst_mid");
    step(0, 0, 0, fb(16'h0, 32'h72, 16'h4B60), 0, 0, 0,
         mk(5'b01001, 3, 3, 0, 0, 0, 32'h72, 0), "after_rst_regs");
    step(0, 0, 0, fb(16'h0, 32'h73, 16'h0000), 0, 0, 0,
         mk(5'd0, 0, 0, 0, 0, 0, 32'h73, 0), "after_rst_r0");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
